// File: rtl/ddr_native_cmd_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : ddr_native_cmd_packer_if
// Brief    : Burst request, write-data and packed-beat channels of the DDR
//            native command packer.
// Revision : 1.0 - initial release
// ============================================================================
interface ddr_native_cmd_packer_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256
);
  // burst request channel
  logic                                 req_valid;
  logic                                 req_ready;
  logic [2:0]                           req_cmd;
  logic [ADDR_WIDTH-1:0]                req_addr;
  logic [8:0]                           req_len;
  // write-data channel
  logic                                 wd_valid;
  logic                                 wd_ready;
  logic [DATA_WIDTH-1:0]                wd_data;
  logic                                 wd_last;
  // packed beat channel {cmd, addr, data}
  logic                                 out_valid;
  logic                                 out_ready;
  logic [ADDR_WIDTH+DATA_WIDTH+2:0]     out_data;
  logic                                 out_last;
  logic [8:0]                           out_cnt;
  // sticky length-mismatch flag
  logic                                 len_err;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_len,
    input  wd_valid, wd_data, wd_last,
    input  out_ready,
    output req_ready, wd_ready,
    output out_valid, out_data, out_last, out_cnt,
    output len_err
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_len,
    output wd_valid, wd_data, wd_last,
    output out_ready,
    input  req_ready, wd_ready,
    input  out_valid, out_data, out_last, out_cnt,
    input  len_err
  );
endinterface
`default_nettype wire

// File: rtl/ddr_native_cmd_packer.sv
`default_nettype none
// ============================================================================
// Module   : ddr_native_cmd_packer
// Brief    : Expands a burst request into per-beat {cmd, addr, data} words for
//            a DDR native app port, through a single output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module ddr_native_cmd_packer #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_STEP  = 8
) (
  input wire                      clock,
  input wire                      rst_n,
  ddr_native_cmd_packer_if.slave  bus
);

  localparam int OUT_WIDTH = ADDR_WIDTH + DATA_WIDTH + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  localparam logic [2:0]            c_CMD_WR    = 3'b000;
  localparam logic [2:0]            c_CMD_RD    = 3'b001;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_STEP = ADDR_WIDTH'(ADDR_STEP);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic                  r_rst_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [8:0]            r_len;
  logic [8:0]            r_cnt;
  logic                  r_out_valid;
  logic [OUT_WIDTH-1:0]  r_out_data;
  logic                  r_out_last;
  logic [8:0]            r_out_cnt;
  logic                  r_len_err;

  logic                  w_slot_free;
  logic                  w_req_ready;
  logic                  w_wd_ready;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_last_beat;
  logic [2:0]            w_beat_cmd;
  logic [DATA_WIDTH-1:0] w_beat_data;

  // The output register may take a new beat when empty or being drained.
  assign w_slot_free = !r_out_valid || bus.out_ready;
  assign w_last_beat = (r_cnt == r_len);
  assign w_accept    = bus.req_valid && w_req_ready;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: dispatch on command, return to idle once the last beat loads.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.req_cmd == c_CMD_WR) begin
            w_next_state = S_WRITE;
          end else if (bus.req_cmd == c_CMD_RD) begin
            w_next_state = S_READ;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_WRITE, S_READ: begin
        if (w_load && w_last_beat) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded handshakes and beat-load strobe; req_ready waits one clock after reset release.
  always_comb begin
    w_req_ready = 1'b0;
    w_wd_ready  = 1'b0;
    w_load      = 1'b0;
    w_beat_cmd  = c_CMD_WR;
    w_beat_data = bus.wd_data;
    case (r_state)
      S_IDLE: begin
        w_req_ready = r_rst_done;
      end
      S_WRITE: begin
        w_wd_ready = w_slot_free;
        w_load     = w_slot_free && bus.wd_valid;
      end
      S_READ: begin
        w_load      = w_slot_free;
        w_beat_cmd  = c_CMD_RD;
        w_beat_data = '0;
      end
      default: begin
        w_req_ready = 1'b0;
      end
    endcase
  end

  // Marks the first clock after reset release.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Burst context: latch on accept, advance address and beat counter per loaded beat.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_addr <= bus.req_addr;
      r_len  <= bus.req_len;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_addr <= r_addr + c_ADDR_STEP;
      r_cnt  <= r_cnt + 9'd1;
    end
  end

  // Output register stage: load a beat, drain when accepted, hold while stalled.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_cnt   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {w_beat_cmd, r_addr, w_beat_data};
      r_out_last  <= w_last_beat;
      r_out_cnt   <= r_cnt;
    end else if (w_slot_free) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flag when upstream wd_last disagrees with the requested length.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_len_err <= 1'b0;
    end else if ((r_state == S_WRITE) && w_load && (bus.wd_last != w_last_beat)) begin
      r_len_err <= 1'b1;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.wd_ready  = w_wd_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.len_err   = r_len_err;

endmodule
`default_nettype wire
